dds_phase_engine: RTL and testbench
===================================

Name: dds_phase_engine

Overview:
- Phase-generation front end of the function generator: prescaler, gear-to-step decoder and phase accumulator in one block.
- Divides the 50 MHz system clock by DIV_RATIO into a single-cycle update tick.
- Maps a 2-bit frequency gear to a phase step.
- Accumulates the step into a PHASE_W-bit phase word that addresses the downstream waveform ROM.

Parameters:
- DIV_RATIO, 200, system-clock cycles per phase update (>= 2).
- PHASE_W, 8, phase accumulator / init / step width (>= 4).

Ports:
- clk  input  1  system clock (50 MHz nominal); the only clock in the block.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  1 = accumulate; 0 = hold phase at init_phase and clear prescaler.
- gears  input  2  frequency gear select.
- init_phase  input  PHASE_W  initial phase loaded while en=0.
- f_step  output  PHASE_W  decoded phase step (combinational from gears).
- tick  output  1  registered one-cycle pulse marking each phase update.
- phase  output  PHASE_W  registered accumulator value.

Behaviour:
- Reset (rstn=0, asynchronous, dominates everything): prescaler count = 0, tick = 0, phase = 0. Release is synchronous to the next clk rising edge.
- Single clock domain. No derived or gated clocks; the prescaler produces an enable only.
- Gear decode: f_step = 1 << gears, i.e. 0→1, 1→2, 2→4, 3→8. Zero-extended to PHASE_W.
- en=0 at a rising edge:
  - count <= 0, tick <= 0, phase <= init_phase.
  - init_phase is reloaded every cycle while en=0.
- en=1 at a rising edge, count < DIV_RATIO-1:
  - count <= count+1, tick <= 0, phase holds.
- en=1 at a rising edge, count == DIV_RATIO-1:
  - count <= 0, tick <= 1, phase <= (phase + f_step) mod 2^PHASE_W.
  - f_step uses gears as sampled on that edge.
- Latency: the first update occurs on the DIV_RATIO-th rising edge that samples en=1. Subsequent updates occur exactly every DIV_RATIO edges. tick is high during the cycle in which the new phase is first visible.
- Wrap-around: the accumulator overflows silently modulo 2^PHASE_W. No saturation and no carry output.
- Gear change mid-stream: takes effect at the next update edge. No prescaler restart and no phase jump.
- init_phase changes while en=1 are ignored.
- en deasserted mid-period: prescaler progress is discarded. On re-enable the count restarts from 0, so a full DIV_RATIO cycles elapse before the next update.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for clk.
- tick is never high for two consecutive cycles (DIV_RATIO >= 2).

Test Plan:
- Reset: hold rstn=0 with en=1 and gears=3 → phase=0, tick=0, f_step=8. Assert rstn mid-count → phase returns to 0 without a clock edge.
- Init load: rstn=1, en=0, init_phase=128 → phase=128 after 1 edge and stays 128 for 1000 cycles; tick stays 0.
- Ramp, gears=0, init 128:
  - Raise en → phase=129 and tick=1 on the 200th edge.
  - phase=130 on the 400th edge.
  - Exactly one tick per 200 cycles.
- Wrap, gears=3, init 128: after 16 ticks (3200 cycles) phase=0; the next tick gives 8.
- Gear change: switch gears 0→2 midway between ticks → the next update adds 4. Sweep gears 0..3 and check f_step = 1, 2, 4, 8.
- En toggle: drop en for 1 cycle at count 150 → phase reloads init_phase; the next tick arrives 200 cycles after en returns high.

Source files
------------

// File: rtl/dds_phase_engine.sv
// dds_phase_engine
// Phase-generation front end: a prescaler turns the system clock into a
// single-cycle update enable, the 2-bit gear selects a power-of-two phase
// step, and the accumulator adds that step on every update.
// The accumulator wraps silently; its value addresses the waveform ROM.
module dds_phase_engine #(
  parameter int DIV_RATIO = 200,  // system-clock cycles per phase update (>= 2)
  parameter int PHASE_W   = 8     // accumulator / init / step width (>= 4)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [1:0]         gears,
  input  logic [PHASE_W-1:0] init_phase,
  output logic [PHASE_W-1:0] f_step,
  output logic               tick,
  output logic [PHASE_W-1:0] phase
);

  // Counter runs 0 .. DIV_RATIO-1; the last value marks the update edge.
  localparam int                CNT_W    = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_RATIO - 1);

  logic [CNT_W-1:0]   r_count;
  logic               r_tick;
  logic [PHASE_W-1:0] r_phase;
  logic               w_update;

  // Gear decode: one-hot step 1 << gears, zero-extended to the phase width.
  // Only the low four bits can ever be set.
  generate
    for (genvar gi = 0; gi < PHASE_W; gi++) begin : g_step
      if (gi < 4) begin : g_live
        assign f_step[gi] = (gears == 2'(gi));
      end else begin : g_zero
        assign f_step[gi] = 1'b0;
      end
    end
  endgenerate

  // An update happens on the enabled edge that closes a full prescaler period.
  assign w_update = en && (r_count == CNT_LAST);

  // Prescaler: counts enabled edges; disabling discards partial progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (!en || w_update) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Update tick: high for exactly the cycle in which the new phase is visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_update;
    end
  end

  // Accumulator: tracks init_phase while idle, adds the step on each update
  // (modulo 2^PHASE_W), and ignores init_phase once running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (!en) begin
      r_phase <= init_phase;
    end else if (w_update) begin
      r_phase <= r_phase + f_step;
    end
  end

  assign tick  = r_tick;
  assign phase = r_phase;

endmodule

// File: tb/tb_dds_phase_engine.sv
// Self-checking bench for dds_phase_engine: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the phase
// generator (edge counting since enable, modular phase arithmetic).
module tb_dds_phase_engine;

  localparam int DIV = 200;
  localparam int PW  = 8;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [1:0]    gears;
  logic [PW-1:0] init_phase;
  logic [PW-1:0] f_step;
  logic          tick;
  logic [PW-1:0] phase;

  int checks;
  int failures;

  // Behavioural model state
  int m_edges;   // enabled edges since the start of the current period
  int m_phase;
  int m_tick;

  dds_phase_engine #(.DIV_RATIO(DIV), .PHASE_W(PW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .gears      (gears),
    .init_phase (init_phase),
    .f_step     (f_step),
    .tick       (tick),
    .phase      (phase)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_phase = 0;
    m_tick  = 0;
  endtask

  // One rising edge: advance the model from the sampled inputs, then compare
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else if (!en) begin
      m_edges = 0;
      m_tick  = 0;
      m_phase = int'(init_phase);
    end else begin
      m_edges = m_edges + 1;
      if (m_edges == DIV) begin
        m_edges = 0;
        m_tick  = 1;
        m_phase = (m_phase + (1 << gears)) % (1 << PW);
      end else begin
        m_tick = 0;
      end
    end
    @(negedge clk);
    check_val("model_phase", 32'(phase), 32'(m_phase));
    check_val("model_tick", 32'(tick), 32'(m_tick));
    check_val("model_fstep", 32'(f_step), 32'(1 << gears));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse reset between edges and confirm outputs clear without a clock edge.
  task automatic async_reset_pulse(input string tag);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_phase"}, 32'(phase), 32'd0);
    check_val({tag, "_tick"}, 32'(tick), 32'd0);
    step();
    rstn = 1'b1;
  endtask

  int tick_count;
  logic [PW-1:0] step_table [4];

  initial begin
    checks     = 0;
    failures   = 0;
    tick_count = 0;
    model_reset();
    step_table[0] = 8'd1;
    step_table[1] = 8'd2;
    step_table[2] = 8'd4;
    step_table[3] = 8'd8;

    // Reset held with en=1, gears=3
    rstn       = 1'b0;
    en         = 1'b1;
    gears      = 2'd3;
    init_phase = '0;
    run(5);
    check_val("rst_phase", 32'(phase), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_fstep", 32'(f_step), 32'd8);

    // Init load: phase follows init_phase while disabled, no ticks
    rstn       = 1'b1;
    en         = 1'b0;
    init_phase = 8'd128;
    step();
    check_val("init_first", 32'(phase), 32'd128);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tick) tick_count++;
    end
    check_val("init_hold", 32'(phase), 32'd128);
    check_val("init_noticks", 32'(tick_count), 32'd0);

    // Ramp with gears=0
    gears = 2'd0;
    en    = 1'b1;
    run(199);
    check_val("ramp_pre_phase", 32'(phase), 32'd128);
    check_val("ramp_pre_tick", 32'(tick), 32'd0);
    step();
    check_val("ramp1_phase", 32'(phase), 32'd129);
    check_val("ramp1_tick", 32'(tick), 32'd1);
    tick_count = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tick) tick_count++;
    end
    check_val("ramp2_phase", 32'(phase), 32'd130);
    check_val("ramp2_ticks", 32'(tick_count), 32'd1);

    // Wrap with gears=3 from 128: 16 updates reach 0, the next gives 8
    en    = 1'b0;
    gears = 2'd3;
    step();
    check_val("wrap_load", 32'(phase), 32'd128);
    en = 1'b1;
    init_phase = 8'd77;  // ignored while running
    tick_count = 0;
    for (int i = 0; i < 16 * DIV; i++) begin
      step();
      if (tick) tick_count++;
    end
    check_val("wrap_ticks", 32'(tick_count), 32'd16);
    check_val("wrap_zero", 32'(phase), 32'd0);
    run(DIV);
    check_val("wrap_next", 32'(phase), 32'd8);

    // Gear change midway between updates: next update adds 4
    gears = 2'd0;
    run(DIV / 2);
    gears = 2'd2;
    run(DIV / 2);
    check_val("gear_chg_phase", 32'(phase), 32'd12);
    check_val("gear_chg_tick", 32'(tick), 32'd1);
    for (int g = 0; g < 4; g++) begin
      gears = 2'(g);
      #1;
      check_val("gear_sweep", 32'(f_step), 32'(step_table[g]));
    end
    gears = 2'd2;

    // En dropped for one cycle at count 150
    init_phase = 8'd128;
    run(150);
    en = 1'b0;
    step();
    check_val("entog_reload", 32'(phase), 32'd128);
    en = 1'b1;
    run(DIV - 1);
    check_val("entog_pre_phase", 32'(phase), 32'd128);
    check_val("entog_pre_tick", 32'(tick), 32'd0);
    step();
    check_val("entog_phase", 32'(phase), 32'd132);
    check_val("entog_tick", 32'(tick), 32'd1);

    // Asynchronous reset mid-count
    run(73);
    async_reset_pulse("async_rst");
    run(3);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      en         = ($urandom_range(0, 199) != 0);
      init_phase = PW'($urandom);
      if ($urandom_range(0, 39) == 0) gears = 2'($urandom);
      step();
      if ($urandom_range(0, 999) == 0) async_reset_pulse("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
